// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 encodings, FSM states and
// the request legality check.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StWait,
      StWr,
      StErr
   } lsu_state_e;

   function automatic logic is_half(input logic [2:0] funct3);
      return (funct3 == F3_H) || (funct3 == F3_HU);
   endfunction

   function automatic logic is_legal_funct3(input logic [2:0] funct3);
      return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
             (funct3 == F3_BU) || (funct3 == F3_HU);
   endfunction

   // A request must be exactly one of load/store, use a defined size and be naturally aligned.
   function automatic logic req_illegal(input logic       rd,
                                        input logic       wr,
                                        input logic [2:0] funct3,
                                        input logic [1:0] offset);
      logic bad;
      bad = (rd == wr) || !is_legal_funct3(funct3);
      if (is_half(funct3) && offset[0]) begin
         bad = 1'b1;
      end
      if ((funct3 == F3_W) && (offset != 2'b00)) begin
         bad = 1'b1;
      end
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: load extraction with sign/zero extension and the
// read-modify-write merge of sub-word store data into a memory word.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] word_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [1:0]      offset_i,
   input  logic [2:0]      funct3_i,
   output logic [XLEN-1:0] rdata_o,
   output logic [XLEN-1:0] merged_o
);

   logic [4:0]      shamt;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] lane_mask;
   logic [XLEN-1:0] lane_mask_sh;

   assign shamt   = {offset_i, 3'b000};
   assign shifted = word_i >> shamt;

   always_comb begin
      rdata_o = '0;
      case (funct3_i)
         F3_B:    rdata_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         F3_H:    rdata_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         F3_W:    rdata_o = word_i;
         F3_BU:   rdata_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
         F3_HU:   rdata_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default: rdata_o = '0;
      endcase
   end

   // Only the addressed byte/halfword lanes take store data; the rest keep memory contents.
   always_comb begin
      lane_mask = '0;
      if (funct3_i == F3_W) begin
         lane_mask = '1;
      end else if (funct3_i[1:0] == 2'b01) begin
         lane_mask[15:0] = '1;
      end else begin
         lane_mask[7:0] = '1;
      end
      lane_mask_sh = lane_mask << shamt;
      merged_o     = (word_i & ~lane_mask_sh) | ((wdata_i << shamt) & lane_mask_sh);
   end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns RV32I loads and stores into single-cycle word reads and
// writes on the data memory, using read-modify-write for byte and halfword stores.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned XLEN   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_read,
   input  logic              req_write,
   input  logic [2:0]        req_funct3,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] dm_address,
   output logic [XLEN-1:0]   dm_data_in,
   output logic              dm_ReadEnable,
   output logic              dm_WriteEnable,
   input  logic [XLEN-1:0]   dm_memData
);

   lsu_state_e      state_q;
   logic [1:0]      offset_q;
   logic [2:0]      funct3_q;
   logic            write_q;
   logic [XLEN-1:0] wdata_q;

   logic            req_err;
   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] merged_data;
   logic            unused_addr;

   assign req_ready   = (state_q == StIdle);
   assign req_err     = req_illegal(req_read, req_write, req_funct3, req_addr[1:0]);
   // Upper address bits alias; the memory only sees the word index.
   assign unused_addr = ^req_addr[XLEN-1:ADDR_W+2];

   lsu_align #(
      .XLEN(XLEN)
   ) u_align (
      .word_i  (dm_memData),
      .wdata_i (wdata_q),
      .offset_i(offset_q),
      .funct3_i(funct3_q),
      .rdata_o (load_data),
      .merged_o(merged_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= StIdle;
         offset_q       <= 2'b00;
         funct3_q       <= F3_B;
         write_q        <= 1'b0;
         wdata_q        <= '0;
         resp_valid     <= 1'b0;
         resp_err       <= 1'b0;
         resp_rdata     <= '0;
         dm_ReadEnable  <= 1'b0;
         dm_WriteEnable <= 1'b0;
         dm_address     <= '0;
         dm_data_in     <= '0;
      end else begin
         // Strobes and the response are single-cycle pulses unless a state re-asserts them.
         resp_valid     <= 1'b0;
         resp_err       <= 1'b0;
         resp_rdata     <= '0;
         dm_ReadEnable  <= 1'b0;
         dm_WriteEnable <= 1'b0;

         case (state_q)
            StIdle: begin
               if (req_valid) begin
                  offset_q <= req_addr[1:0];
                  funct3_q <= req_funct3;
                  write_q  <= req_write;
                  wdata_q  <= req_wdata;
                  if (req_err) begin
                     state_q <= StErr;
                  end else if (req_write && (req_funct3 == F3_W)) begin
                     dm_address     <= req_addr[ADDR_W+1:2];
                     dm_data_in     <= req_wdata;
                     dm_WriteEnable <= 1'b1;
                     state_q        <= StWr;
                  end else begin
                     dm_address    <= req_addr[ADDR_W+1:2];
                     dm_ReadEnable <= 1'b1;
                     state_q       <= StRd;
                  end
               end
            end

            StRd: begin
               state_q <= StWait;
            end

            StWait: begin
               if (write_q) begin
                  dm_data_in     <= merged_data;
                  dm_WriteEnable <= 1'b1;
                  state_q        <= StWr;
               end else begin
                  resp_rdata <= load_data;
                  resp_valid <= 1'b1;
                  state_q    <= StIdle;
               end
            end

            StWr: begin
               resp_valid <= 1'b1;
               state_q    <= StIdle;
            end

            StErr: begin
               resp_valid <= 1'b1;
               resp_err   <= 1'b1;
               state_q    <= StIdle;
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a registered word memory model and an
// independent lane/extension reference.
module tb_load_store_unit;
   import lsu_pkg::*;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned XLEN   = 32;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          re;
      int          we;
   } exp_t;

   logic              clk;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic              req_read;
   logic              req_write;
   logic [2:0]        req_funct3;
   logic [XLEN-1:0]   req_addr;
   logic [XLEN-1:0]   req_wdata;
   logic              resp_valid;
   logic [XLEN-1:0]   resp_rdata;
   logic              resp_err;
   logic [ADDR_W-1:0] dm_address;
   logic [XLEN-1:0]   dm_data_in;
   logic              dm_ReadEnable;
   logic              dm_WriteEnable;
   logic [XLEN-1:0]   dm_memData;

   logic [31:0] mem     [0:1023];
   logic [31:0] ref_mem [0:1023];
   logic        mem_clr;
   logic        bd_we;
   logic [9:0]  bd_idx;
   logic [31:0] bd_data;

   exp_t        exp_q[$];
   int          acc_q[$];
   int          cyc;
   int          re_cnt;
   int          we_cnt;
   bit          both_seen;
   logic [9:0]  wr_addr;
   logic [31:0] wr_data;
   int          n_checks;
   int          n_pass;

   load_store_unit #(
      .ADDR_W(ADDR_W),
      .XLEN  (XLEN)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_read      (req_read),
      .req_write     (req_write),
      .req_funct3    (req_funct3),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .resp_valid    (resp_valid),
      .resp_rdata    (resp_rdata),
      .resp_err      (resp_err),
      .dm_address    (dm_address),
      .dm_data_in    (dm_data_in),
      .dm_ReadEnable (dm_ReadEnable),
      .dm_WriteEnable(dm_WriteEnable),
      .dm_memData    (dm_memData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // Data memory: read data registered one cycle after the ReadEnable edge.
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 1024; i++) mem[i] <= '0;
      end else begin
         if (bd_we) mem[bd_idx] <= bd_data;
         if (dm_WriteEnable) mem[dm_address] <= dm_data_in;
      end
      if (dm_ReadEnable) dm_memData <= mem[dm_address];
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   function automatic logic ref_err(input logic rd, input logic wr, input logic [2:0] f,
                                    input logic [1:0] a);
      logic e;
      e = (rd == wr) || (f == 3'b011) || (f == 3'b110) || (f == 3'b111);
      if (((f == F3_H) || (f == F3_HU)) && a[0]) e = 1'b1;
      if ((f == F3_W) && (a != 2'b00)) e = 1'b1;
      return e;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a,
                                            input logic [2:0] f);
      logic [7:0]  b;
      logic [15:0] h;
      case (a)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = a[1] ? w[31:16] : w[15:0];
      case (f)
         F3_B:    return {{24{b[7]}}, b};
         F3_H:    return {{16{h[15]}}, h};
         F3_W:    return w;
         F3_BU:   return {24'd0, b};
         F3_HU:   return {16'd0, h};
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] d,
                                             input logic [1:0] a, input logic [2:0] f);
      logic [31:0] r;
      r = w;
      if (f == F3_W) begin
         r = d;
      end else if (f == F3_H) begin
         if (a[1]) r[31:16] = d[15:0];
         else r[15:0] = d[15:0];
      end else begin
         case (a)
            2'd0:    r[7:0]   = d[7:0];
            2'd1:    r[15:8]  = d[7:0];
            2'd2:    r[23:16] = d[7:0];
            default: r[31:24] = d[7:0];
         endcase
      end
      return r;
   endfunction

   // Negedge monitor: strobe accounting, accept timestamps and scoreboard compare.
   always @(negedge clk) begin
      exp_t e;
      int   a;
      if (reset) begin
         acc_q.delete();
      end else begin
         re_cnt += int'(dm_ReadEnable);
         we_cnt += int'(dm_WriteEnable);
         if (dm_ReadEnable && dm_WriteEnable) both_seen = 1'b1;
         if (dm_WriteEnable) begin
            wr_addr = dm_address;
            wr_data = dm_data_in;
         end
         if (resp_valid) begin
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
               check("unexpected_resp", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               a = acc_q.pop_front();
               check("rdata", resp_rdata, e.rdata);
               check("err", 32'(resp_err), 32'(e.err));
               check("latency", 32'(cyc - a), 32'(e.lat));
               check("re_strobes", 32'(re_cnt), 32'(e.re));
               check("we_strobes", 32'(we_cnt), 32'(e.we));
               check("ready_at_resp", 32'(req_ready), 32'd1);
            end
            re_cnt = 0;
            we_cnt = 0;
         end
         if (req_valid && req_ready) acc_q.push_back(cyc + 1);
      end
   end

   task automatic poke(input logic [9:0] idx, input logic [31:0] data);
      bd_we   = 1'b1;
      bd_idx  = idx;
      bd_data = data;
      @(posedge clk);
      #1;
      bd_we        = 1'b0;
      ref_mem[idx] = data;
   endtask

   task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit track,
                         input bit use_plan, input logic [31:0] plan);
      exp_t       e;
      logic [9:0] idx;
      bit         accepted;
      idx     = addr[11:2];
      e.err   = ref_err(rd, wr, f3, addr[1:0]);
      e.rdata = 32'd0;
      e.re    = 0;
      e.we    = 0;
      if (e.err) begin
         e.lat = 1;
      end else if (rd) begin
         e.lat   = 2;
         e.re    = 1;
         e.rdata = use_plan ? plan : ref_load(ref_mem[idx], addr[1:0], f3);
      end else begin
         e.we  = 1;
         e.lat = (f3 == F3_W) ? 1 : 3;
         e.re  = (f3 == F3_W) ? 0 : 1;
         if (track) ref_mem[idx] = ref_store(ref_mem[idx], wdata, addr[1:0], f3);
      end
      if (track) exp_q.push_back(e);
      req_valid  = 1'b1;
      req_read   = rd;
      req_write  = wr;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      accepted   = 1'b0;
      for (int i = 0; i < 20 && !accepted; i++) begin
         @(negedge clk);
         accepted = req_ready;
      end
      if (!accepted) check("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_wait();
      req_valid = 1'b0;
      for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         check("drain_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [2:0]  f3;
      logic [31:0] addr;
      logic        rd;
      logic        wr;
      int          r;
      n_checks   = 0;
      n_pass     = 0;
      cyc        = 0;
      re_cnt     = 0;
      we_cnt     = 0;
      both_seen  = 1'b0;
      wr_addr    = '0;
      wr_data    = '0;
      reset      = 1'b1;
      mem_clr    = 1'b1;
      bd_we      = 1'b0;
      bd_idx     = '0;
      bd_data    = '0;
      req_valid  = 1'b0;
      req_read   = 1'b0;
      req_write  = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = '0;
      req_wdata  = '0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      mem_clr = 1'b0;
      reset   = 1'b0;

      check("rst_ctrl", 32'({resp_valid, resp_err, dm_ReadEnable, dm_WriteEnable}), 32'd0);
      check("rst_rdata", resp_rdata, 32'd0);
      check("rst_addr", 32'(dm_address), 32'd0);
      check("rst_wdata", dm_data_in, 32'd0);
      check("rst_ready", 32'(req_ready), 32'd1);

      // Word store
      do_req(1'b0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 32'd0);
      idle_wait();
      check("sw_addr", 32'(wr_addr), 32'd4);
      check("sw_data", wr_data, 32'hDEADBEEF);
      check("sw_mem", mem[4], 32'hDEADBEEF);

      // Sub-word loads with sign/zero extension
      poke(10'd4, 32'h80FF7F01);
      do_req(1'b1, 1'b0, F3_B, 32'h13, 32'd0, 1'b1, 1'b1, 32'hFFFFFF80);
      do_req(1'b1, 1'b0, F3_BU, 32'h13, 32'd0, 1'b1, 1'b1, 32'h00000080);
      do_req(1'b1, 1'b0, F3_H, 32'h12, 32'd0, 1'b1, 1'b1, 32'hFFFF80FF);
      do_req(1'b1, 1'b0, F3_HU, 32'h10, 32'd0, 1'b1, 1'b1, 32'h00007F01);
      idle_wait();

      // Byte store via read-modify-write, then read back and an aliased read
      poke(10'd4, 32'h11223344);
      do_req(1'b0, 1'b1, F3_B, 32'h11, 32'h000000AA, 1'b1, 1'b0, 32'd0);
      idle_wait();
      check("sb_data", wr_data, 32'h1122AA44);
      check("sb_mem", mem[4], 32'h1122AA44);
      do_req(1'b1, 1'b0, F3_W, 32'h10, 32'd0, 1'b1, 1'b1, 32'h1122AA44);
      do_req(1'b1, 1'b0, F3_W, 32'h1010, 32'd0, 1'b1, 1'b1, 32'h1122AA44);
      idle_wait();

      // Misaligned and illegal requests
      do_req(1'b1, 1'b0, F3_W, 32'h12, 32'd0, 1'b1, 1'b0, 32'd0);
      do_req(1'b0, 1'b1, F3_H, 32'h13, 32'h5555, 1'b1, 1'b0, 32'd0);
      do_req(1'b1, 1'b0, 3'b011, 32'h10, 32'd0, 1'b1, 1'b0, 32'd0);
      do_req(1'b1, 1'b1, F3_W, 32'h10, 32'd0, 1'b1, 1'b0, 32'd0);
      idle_wait();
      check("err_mem", mem[4], 32'h1122AA44);

      // Reset while a halfword store sits in WAIT
      poke(10'd5, 32'hCAFEF00D);
      re_cnt = 0;
      we_cnt = 0;
      do_req(1'b0, 1'b1, F3_H, 32'h16, 32'h00001234, 1'b0, 1'b0, 32'd0);
      @(posedge clk);
      #1;
      reset     = 1'b1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("mid_rst_ctrl", 32'({resp_valid, resp_err, dm_ReadEnable, dm_WriteEnable}), 32'd0);
      check("mid_rst_rdata", resp_rdata, 32'd0);
      check("mid_rst_addr", 32'(dm_address), 32'd0);
      check("mid_rst_wdata", dm_data_in, 32'd0);
      check("mid_rst_ready", 32'(req_ready), 32'd1);
      repeat (4) @(posedge clk);
      #1;
      check("mid_rst_we", 32'(we_cnt), 32'd0);
      check("mid_rst_re", 32'(re_cnt), 32'd1);
      check("mid_rst_mem", mem[5], 32'hCAFEF00D);
      re_cnt = 0;
      we_cnt = 0;

      // Back-to-back with req_valid held high
      do_req(1'b1, 1'b0, F3_W, 32'h10, 32'd0, 1'b1, 1'b1, 32'h1122AA44);
      do_req(1'b0, 1'b1, F3_W, 32'h20, 32'h12345678, 1'b1, 1'b0, 32'd0);
      do_req(1'b1, 1'b0, F3_B, 32'h21, 32'd0, 1'b1, 1'b1, 32'h00000056);
      idle_wait();

      // Random mix over a few words, with aliased upper address bits
      for (int i = 0; i < 4; i++) poke(10'(i), $urandom);
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         rd = (r < 4) || (r == 8);
         wr = ((r >= 4) && (r < 8)) || (r == 8);
         case ($urandom_range(0, 5))
            0:       f3 = F3_B;
            1:       f3 = F3_H;
            2:       f3 = F3_W;
            3:       f3 = F3_BU;
            4:       f3 = F3_HU;
            default: f3 = 3'b110;
         endcase
         if (wr && !rd && (f3 != F3_W)) f3 = f3[0] ? F3_H : F3_B;
         addr = {19'd0, 1'($urandom_range(0, 1)), 8'd0, 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3))};
         do_req(rd, wr, f3, addr, $urandom, 1'b1, 1'b0, 32'd0);
         if ($urandom_range(0, 2) == 0) idle_wait();
      end
      idle_wait();

      check("strobe_overlap", 32'(both_seen), 32'd0);
      for (int i = 0; i < 9; i++) check($sformatf("mem_word%0d", i), mem[i], ref_mem[i]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
